// File: rtl/alu_seq_core.sv
// Sequential ALU core: valid/ready instruction handshake, NZCV flags, ARM-style conditions, iterative MUL.
// Define ALU_CARRY_IN_EN to enable ADC (opcode C) and SBC (opcode D); otherwise opcodes C-F are illegal.
//
// state | meaning
// IDLE  | output register empty
// MUL   | multiply iterating, MUL_BITS multiplier bits per cycle
// HOLD  | result presented, out_valid=1

module alu_seq_core #(
   parameter int WIDTH    = 32,
   parameter int IMM_W    = 16,
   parameter int MUL_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op_code,
   input  logic [3:0]       cond,
   input  logic             s,
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   input  logic [IMM_W-1:0] iv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             out_wr,
   output logic             out_skip,
   output logic             out_illegal,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam int SH_W   = $clog2(WIDTH);
   localparam int N_ITER = WIDTH / MUL_BITS;
   localparam int CNT_W  = $clog2(N_ITER + 1);
   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_HOLD
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       flag_q;
   logic             accept;
   logic             cond_pass;
   logic             start_mul;
   logic             mul_last;

   logic [WIDTH-1:0] exe_res;
   logic [3:0]       exe_flags;
   logic             exe_wr;
   logic             exe_illegal;
   logic             upd;
   logic             c_new;
   logic             v_new;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             add_v;
   logic             sub_v;
   logic [SH_W-1:0]  amt;
   logic [SH_W-1:0]  amt_m1;
   logic [SH_W-1:0]  amt_neg;
   logic [WIDTH-1:0] lsr_res;
   logic [WIDTH-1:0] lsl_res;
   logic [WIDTH-1:0] ror_res;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0] mul_cnt;
   logic             mul_s;

`ifdef ALU_CARRY_IN_EN
   logic [WIDTH:0]   adc_full;
   logic [WIDTH:0]   sbc_full;
   logic             adc_v;
   logic             sbc_v;
`endif

   assign flags = flag_q;

   always_comb begin
      cond_pass = 1'b1;
      case (cond)
         4'h0: cond_pass = flag_q[FZ];
         4'h1: cond_pass = !flag_q[FZ];
         4'h2: cond_pass = flag_q[FC];
         4'h3: cond_pass = !flag_q[FC];
         4'h4: cond_pass = flag_q[FN];
         4'h5: cond_pass = !flag_q[FN];
         4'h6: cond_pass = flag_q[FV];
         4'h7: cond_pass = !flag_q[FV];
         4'h8: cond_pass = flag_q[FC] && !flag_q[FZ];
         4'h9: cond_pass = !flag_q[FC] || flag_q[FZ];
         4'hA: cond_pass = (flag_q[FN] == flag_q[FV]);
         4'hB: cond_pass = (flag_q[FN] != flag_q[FV]);
         4'hC: cond_pass = !flag_q[FZ] && (flag_q[FN] == flag_q[FV]);
         4'hD: cond_pass = flag_q[FZ] || (flag_q[FN] != flag_q[FV]);
         default: cond_pass = 1'b1;
      endcase
   end

   assign add_full = {1'b0, reg1} + {1'b0, reg2};
   assign sub_full = {1'b0, reg1} + {1'b0, ~reg2} + {{WIDTH{1'b0}}, 1'b1};
   assign add_v    = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (add_full[WIDTH-1] != reg1[WIDTH-1]);
   assign sub_v    = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (sub_full[WIDTH-1] != reg1[WIDTH-1]);

`ifdef ALU_CARRY_IN_EN
   assign adc_full = {1'b0, reg1} + {1'b0, reg2} + {{WIDTH{1'b0}}, flag_q[FC]};
   assign sbc_full = {1'b0, reg1} + {1'b0, ~reg2} + {{WIDTH{1'b0}}, flag_q[FC]};
   assign adc_v    = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (adc_full[WIDTH-1] != reg1[WIDTH-1]);
   assign sbc_v    = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (sbc_full[WIDTH-1] != reg1[WIDTH-1]);
`endif

   // amt_neg is WIDTH-amt modulo WIDTH: the left-shift distance that completes a rotate
   assign amt     = iv[SH_W-1:0];
   assign amt_m1  = amt - SH_W'(1);
   assign amt_neg = -amt;
   assign lsr_res = reg2 >> amt;
   assign lsl_res = reg2 << amt;
   assign ror_res = lsr_res | (reg2 << amt_neg);

   always_comb begin
      exe_res     = '0;
      exe_wr      = 1'b1;
      exe_illegal = 1'b0;
      upd         = s;
      c_new       = flag_q[FC];
      v_new       = flag_q[FV];
      case (op_code)
         4'h0: begin
            exe_res = add_full[WIDTH-1:0];
            c_new   = add_full[WIDTH];
            v_new   = add_v;
         end
         4'h1: begin
            exe_res = sub_full[WIDTH-1:0];
            c_new   = sub_full[WIDTH];
            v_new   = sub_v;
         end
         4'h2: exe_res = '0;
         4'h3: exe_res = reg1 | reg2;
         4'h4: exe_res = reg1 & reg2;
         4'h5: exe_res = reg1 ^ reg2;
         4'h6: exe_res = WIDTH'(iv);
         4'h7: exe_res = reg2;
         4'h8: begin
            exe_res = lsr_res;
            if (amt != '0) c_new = reg2[amt_m1];
         end
         4'h9: begin
            exe_res = lsl_res;
            if (amt != '0) c_new = reg2[amt_neg];
         end
         4'hA: begin
            exe_res = ror_res;
            if (amt != '0) c_new = ror_res[WIDTH-1];
         end
         4'hB: begin
            exe_res = sub_full[WIDTH-1:0];
            c_new   = sub_full[WIDTH];
            v_new   = sub_v;
            upd     = 1'b1;
            exe_wr  = 1'b0;
         end
`ifdef ALU_CARRY_IN_EN
         4'hC: begin
            exe_res = adc_full[WIDTH-1:0];
            c_new   = adc_full[WIDTH];
            v_new   = adc_v;
         end
         4'hD: begin
            exe_res = sbc_full[WIDTH-1:0];
            c_new   = sbc_full[WIDTH];
            v_new   = sbc_v;
         end
`endif
         default: begin
            exe_wr      = 1'b0;
            exe_illegal = 1'b1;
            upd         = 1'b0;
         end
      endcase
      exe_flags = flag_q;
      if (upd) exe_flags = {exe_res[WIDTH-1], (exe_res == '0), c_new, v_new};
   end

   assign acc_nxt   = acc + (mcand * WIDTH'(mplier[MUL_BITS-1:0]));
   assign mul_last  = (mul_cnt == CNT_W'(1));
   assign start_mul = (op_code == 4'h2) && cond_pass;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: in_ready = !rst;
         S_MUL:  busy     = 1'b1;
         S_HOLD: begin
            in_ready  = !rst && out_ready;
            out_valid = 1'b1;
         end
         default: ;
      endcase
      accept = in_valid && in_ready;
      case (state)
         S_IDLE: if (accept) state_nxt = start_mul ? S_MUL : S_HOLD;
         S_MUL:  if (mul_last) state_nxt = S_HOLD;
         S_HOLD: begin
            if (accept)         state_nxt = start_mul ? S_MUL : S_HOLD;
            else if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result      <= '0;
         out_wr      <= 1'b0;
         out_skip    <= 1'b0;
         out_illegal <= 1'b0;
         flag_q      <= '0;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         mul_cnt     <= '0;
         mul_s       <= 1'b0;
      end else if (accept) begin
         if (!cond_pass) begin
            result      <= '0;
            out_wr      <= 1'b0;
            out_skip    <= 1'b1;
            out_illegal <= 1'b0;
         end else if (start_mul) begin
            mcand       <= reg1;
            mplier      <= reg2;
            acc         <= '0;
            mul_cnt     <= CNT_W'(N_ITER);
            mul_s       <= s;
            out_wr      <= 1'b0;
            out_skip    <= 1'b0;
            out_illegal <= 1'b0;
         end else begin
            result      <= exe_res;
            flag_q      <= exe_flags;
            out_wr      <= exe_wr;
            out_skip    <= 1'b0;
            out_illegal <= exe_illegal;
         end
      end else if (state == S_MUL) begin
         mcand   <= mcand << MUL_BITS;
         mplier  <= mplier >> MUL_BITS;
         acc     <= acc_nxt;
         mul_cnt <= mul_cnt - CNT_W'(1);
         if (mul_last) begin
            result <= acc_nxt;
            out_wr <= 1'b1;
            if (mul_s) flag_q[FN:FZ] <= {acc_nxt[WIDTH-1], (acc_nxt == '0)};
         end
      end else if ((state == S_HOLD) && out_ready) begin
         out_wr      <= 1'b0;
         out_skip    <= 1'b0;
         out_illegal <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed scenarios plus a randomized
// stream scored against a plain-arithmetic reference model.
module tb_alu_seq_core;

   localparam int WIDTH    = 32;
   localparam int IMM_W    = 16;
   localparam int MUL_BITS = 4;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op_code;
   logic [3:0]        cond;
   logic              s;
   logic [WIDTH-1:0]  reg1;
   logic [WIDTH-1:0]  reg2;
   logic [IMM_W-1:0]  iv;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic              out_wr;
   logic              out_skip;
   logic              out_illegal;
   logic [3:0]        flags;
   logic              busy;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      logic        wr;
      logic        skip;
      logic        ill;
      logic        res_care;
   } exp_t;

   exp_t       q[$];
   logic [3:0] mfl;

   alu_seq_core #(.WIDTH(WIDTH), .IMM_W(IMM_W), .MUL_BITS(MUL_BITS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_code(op_code), .cond(cond), .s(s), .reg1(reg1), .reg2(reg2), .iv(iv),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .out_wr(out_wr), .out_skip(out_skip), .out_illegal(out_illegal),
      .flags(flags), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic exp_t model(input logic [3:0] op, input logic [3:0] cd, input logic sf,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [15:0] imm, input logic [3:0] fl);
      exp_t e;
      logic n, z, c, v, ci, pass, upd;
      logic [63:0] w;
      longint sv;
      logic [31:0] r;
      int amt;
      {n, z, c, v} = fl;
      ci = c;
      case (cd)
         4'h0: pass = z;
         4'h1: pass = !z;
         4'h2: pass = c;
         4'h3: pass = !c;
         4'h4: pass = n;
         4'h5: pass = !n;
         4'h6: pass = v;
         4'h7: pass = !v;
         4'h8: pass = c && !z;
         4'h9: pass = !c || z;
         4'hA: pass = (n == v);
         4'hB: pass = (n != v);
         4'hC: pass = !z && (n == v);
         4'hD: pass = z || (n != v);
         default: pass = 1'b1;
      endcase
      e.fl = fl; e.res = '0; e.wr = 1'b0; e.skip = 1'b0; e.ill = 1'b0; e.res_care = 1'b1;
      if (!pass) begin
         e.skip = 1'b1;
         return e;
      end
      r = '0; upd = sf; e.wr = 1'b1; amt = int'(imm[4:0]);
      case (op)
         4'h0: begin
            w = 64'(a) + 64'(b); r = w[31:0]; c = w[32];
            sv = longint'($signed(a)) + longint'($signed(b)); v = (sv > SMAX) || (sv < SMIN);
         end
         4'h1, 4'hB: begin
            r = a - b; c = (a >= b);
            sv = longint'($signed(a)) - longint'($signed(b)); v = (sv > SMAX) || (sv < SMIN);
            if (op == 4'hB) begin upd = 1'b1; e.wr = 1'b0; e.res_care = 1'b0; end
         end
         4'h2: begin w = 64'(a) * 64'(b); r = w[31:0]; end
         4'h3: r = a | b;
         4'h4: r = a & b;
         4'h5: r = a ^ b;
         4'h6: r = 32'(imm);
         4'h7: r = b;
         4'h8: if (amt != 0) begin w = {b, 32'h0} >> amt; r = w[63:32]; c = w[31]; end else r = b;
         4'h9: if (amt != 0) begin w = 64'(b) << amt; r = w[31:0]; c = w[32]; end else r = b;
         4'hA: begin w = {b, b} >> amt; r = w[31:0]; if (amt != 0) c = r[31]; end
`ifdef ALU_CARRY_IN_EN
         4'hC: begin
            w = 64'(a) + 64'(b) + 64'(ci); r = w[31:0]; c = w[32];
            sv = longint'($signed(a)) + longint'($signed(b)) + longint'(ci); v = (sv > SMAX) || (sv < SMIN);
         end
         4'hD: begin
            r = a - b - 32'(!ci); c = (64'(a) >= 64'(b) + 64'(!ci));
            sv = longint'($signed(a)) - longint'($signed(b)) - longint'(!ci); v = (sv > SMAX) || (sv < SMIN);
         end
`endif
         default: begin e.ill = 1'b1; e.wr = 1'b0; upd = 1'b0; end
      endcase
      e.res = r;
      if (upd) e.fl = {r[31], (r == 32'h0), c, v};
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic send_op(input logic [3:0] op, input logic [3:0] cd, input logic sf,
                          input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                          output int lat);
      int w;
      @(negedge clk);
      op_code = op; cond = cd; s = sf; reg1 = a; reg2 = b; iv = imm;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); #1; w++; end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op_code = '0; cond = 4'hE; s = 1'b0; reg1 = '0; reg2 = '0; iv = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({out_valid, busy, out_wr, out_skip, out_illegal} !== 5'b0 || result !== '0 || flags !== 4'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b busy=%b wr=%b sk=%b il=%b res=%h fl=%b want all 0",
                  out_valid, busy, out_wr, out_skip, out_illegal, result, flags);
      end
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add_overflow();
      int lat;
      send_op(4'h0, 4'hE, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, lat);
      vectors++;
      if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
      vectors++;
      if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h want 80000000", result); end
      vectors++;
      if (flags !== 4'b1001) begin errors++; $display("FAIL add_flags got %b want 1001", flags); end
      vectors++;
      if (out_wr !== 1'b1 || out_skip !== 1'b0) begin errors++; $display("FAIL add_wr got wr=%b sk=%b want 1/0", out_wr, out_skip); end
   endtask

   task automatic test_cmp_cond();
      int lat;
      send_op(4'hB, 4'hE, 1'b0, 32'd5, 32'd5, 16'h0, lat);
      vectors++;
      if (flags !== 4'b0110 || out_wr !== 1'b0) begin errors++; $display("FAIL cmp_flags got fl=%b wr=%b want 0110/0", flags, out_wr); end
      send_op(4'h0, 4'h0, 1'b0, 32'd1, 32'd2, 16'h0, lat);
      vectors++;
      if (result !== 32'd3 || out_skip !== 1'b0 || out_wr !== 1'b1) begin
         errors++; $display("FAIL eq_add got res=%h sk=%b wr=%b want 00000003/0/1", result, out_skip, out_wr);
      end
      send_op(4'h0, 4'h1, 1'b1, 32'd1, 32'd2, 16'h0, lat);
      vectors++;
      if (lat !== 1 || out_skip !== 1'b1 || result !== '0 || out_wr !== 1'b0 || flags !== 4'b0110) begin
         errors++; $display("FAIL ne_skip got lat=%0d sk=%b res=%h wr=%b fl=%b want 1/1/0/0/0110", lat, out_skip, result, out_wr, flags);
      end
   endtask

   task automatic test_mul();
      int lat, nbusy, bad, vcyc;
      logic [31:0] cap_res;
      logic [3:0] cap_fl;
      send_op(4'h0, 4'hE, 1'b1, 32'h7FFF_FFFF, 32'h1, 16'h0, lat);
      @(negedge clk);
      op_code = 4'h2; cond = 4'hE; s = 1'b1; reg1 = 32'h0001_0000; reg2 = 32'h0001_0000; in_valid = 1'b1;
      @(posedge clk);
      nbusy = 0; bad = 0; vcyc = 0; cap_res = 'x; cap_fl = 'x;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (busy) nbusy++;
         if (busy && in_ready) bad++;
         if (out_valid && vcyc == 0) begin vcyc = cyc; cap_res = result; cap_fl = flags; end
      end
      vectors++;
      if (nbusy !== 8 || bad !== 0) begin errors++; $display("FAIL mul_busy got busy_cycles=%0d ready_during_busy=%0d want 8/0", nbusy, bad); end
      vectors++;
      if (vcyc !== 9) begin errors++; $display("FAIL mul_latency got %0d want 9", vcyc); end
      vectors++;
      if (cap_res !== 32'h0 || cap_fl !== 4'b0101) begin errors++; $display("FAIL mul_result got res=%h fl=%b want 00000000/0101", cap_res, cap_fl); end
      send_op(4'h2, 4'hE, 1'b0, 32'd12345, 32'd6789, 16'h0, lat);
      vectors++;
      if (lat !== 9 || result !== 32'd83810205 || flags !== 4'b0101) begin
         errors++; $display("FAIL mul_small got lat=%0d res=%h fl=%b want 9/04fed79d/0101", lat, result, flags);
      end
   endtask

   task automatic test_shift();
      int lat;
      send_op(4'h8, 4'hE, 1'b1, 32'h0, 32'h8000_0001, 16'h0001, lat);
      vectors++;
      if (result !== 32'h4000_0000 || flags !== 4'b0011) begin errors++; $display("FAIL lsr got res=%h fl=%b want 40000000/0011", result, flags); end
      send_op(4'hA, 4'hE, 1'b1, 32'h0, 32'h1234_5678, 16'h0020, lat);
      vectors++;
      if (result !== 32'h1234_5678 || flags !== 4'b0011) begin errors++; $display("FAIL ror0 got res=%h fl=%b want 12345678/0011", result, flags); end
      send_op(4'h9, 4'hE, 1'b1, 32'h0, 32'h1000_0000, 16'h0004, lat);
      vectors++;
      if (result !== 32'h0 || flags !== 4'b0111) begin errors++; $display("FAIL lsl got res=%h fl=%b want 00000000/0111", result, flags); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      op_code = 4'h0; cond = 4'hE; s = 1'b0; reg1 = 32'd2; reg2 = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || result !== 32'd5 || flags !== 4'b0111 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got v=%b res=%h fl=%b rdy=%b want 1/00000005/0111/0", i, out_valid, result, flags, in_ready);
         end
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; reg1 = 32'd10; reg2 = 32'd20;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || result !== 32'd30 || out_wr !== 1'b1) begin
         errors++; $display("FAIL b2b_result got v=%b res=%h wr=%b want 1/0000001e/1", out_valid, result, out_wr);
      end
   endtask

   task automatic test_reserved();
      int lat;
      logic [3:0] fl_after;
      send_op(4'hC, 4'hE, 1'b1, 32'hFFFF_FFFF, 32'h0, 16'h0, lat);
`ifdef ALU_CARRY_IN_EN
      fl_after = 4'b0110;
      vectors++;
      if (out_illegal !== 1'b0 || result !== 32'h0 || flags !== 4'b0110 || out_wr !== 1'b1) begin
         errors++; $display("FAIL adc got il=%b res=%h fl=%b wr=%b want 0/00000000/0110/1", out_illegal, result, flags, out_wr);
      end
`else
      fl_after = 4'b0111;
      vectors++;
      if (out_illegal !== 1'b1 || result !== 32'h0 || flags !== 4'b0111 || out_wr !== 1'b0) begin
         errors++; $display("FAIL illegal_c got il=%b res=%h fl=%b wr=%b want 1/00000000/0111/0", out_illegal, result, flags, out_wr);
      end
`endif
      send_op(4'hF, 4'hE, 1'b1, 32'd1, 32'd1, 16'h0, lat);
      vectors++;
      if (out_illegal !== 1'b1 || result !== 32'h0 || flags !== fl_after || out_wr !== 1'b0) begin
         errors++; $display("FAIL illegal_f got il=%b res=%h fl=%b wr=%b want 1/00000000/%b/0", out_illegal, result, flags, out_wr, fl_after);
      end
   endtask

   task automatic test_reset_abort();
      bit seen;
      @(negedge clk);
      op_code = 4'h2; cond = 4'hE; s = 1'b1; reg1 = 32'd3; reg2 = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0 || flags !== 4'b0) begin
         errors++; $display("FAIL abort_reset got busy=%b v=%b res=%h fl=%b want 0/0/0/0000", busy, out_valid, result, flags);
      end
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      vectors++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid got out_valid seen=%b want 0", seen); end
   endtask

   task automatic test_random_stream();
      exp_t e;
      mfl = 4'b0000;
      q.delete();
      for (int cyc = 0; cyc < 460; cyc++) begin
         @(negedge clk);
         if (cyc < 400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
         end else begin
            out_ready = 1'b1;
            in_valid  = 1'b0;
         end
         op_code = 4'($urandom_range(0, 15));
         cond    = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 15));
         s       = 1'($urandom_range(0, 1));
         reg1    = pick();
         reg2    = pick();
         iv      = 16'($urandom);
         #1;
         if (busy) begin
            vectors++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stream_busy_ready cyc=%0d got in_ready=%b want 0", cyc, in_ready); end
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stream_extra cyc=%0d got unexpected result %h want none", cyc, result);
            end else begin
               e = q.pop_front();
               if ((e.res_care && result !== e.res) || flags !== e.fl || out_wr !== e.wr ||
                   out_skip !== e.skip || out_illegal !== e.ill) begin
                  errors++;
                  $display("FAIL stream cyc=%0d got res=%h fl=%b wr=%b sk=%b il=%b want res=%h fl=%b wr=%b sk=%b il=%b",
                           cyc, result, flags, out_wr, out_skip, out_illegal, e.res, e.fl, e.wr, e.skip, e.ill);
               end
            end
         end
         if (in_valid && in_ready) begin
            e = model(op_code, cond, s, reg1, reg2, iv, mfl);
            mfl = e.fl;
            q.push_back(e);
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (q.size() != 0) begin errors++; $display("FAIL stream_drain got %0d pending want 0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_cmp_cond();
      test_mul();
      test_shift();
      test_back_to_back();
      test_reserved();
      test_reset_abort();
      test_random_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, sequential successor to the combinational top-level ALU.
- Accepts one instruction per cycle over a valid/ready handshake and holds an internal NZCV flag register.
- Evaluates an ARM-style condition field, registers results, and runs MUL as an iterative multi-cycle operation.
- Sits between register-file read and write-back in the pipeline.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, at least 8.
- IMM_W, 16, immediate (iv) width; must not exceed WIDTH.
- MUL_BITS, 4, multiplier bits retired per MUL iteration; must divide WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  core can accept an instruction this cycle
- op_code  in  4  operation select
- cond  in  4  condition code
- s  in  1  update flags
- reg1  in  WIDTH  operand A
- reg2  in  WIDTH  operand B / shift source
- iv  in  IMM_W  immediate / shift amount
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- out_wr  out  1  result should be written back
- out_skip  out  1  instruction was condition-failed
- out_illegal  out  1  instruction had a reserved opcode
- flags  out  4  current flags {N,Z,C,V}
- busy  out  1  MUL iteration in progress

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE. A reset during a MUL aborts it, and no out_valid is produced for that instruction.
- States and transitions:
  - IDLE: output register empty.
  - MUL: iterating.
  - HOLD: out_valid=1.
  - HOLD -> IDLE on out_ready without a new accept.
  - HOLD stays in HOLD, or goes to MUL, when a new instruction is accepted in the same cycle.
- in_ready = (IDLE) or (HOLD and out_ready). It is 0 in MUL.
- Accept happens on a rising edge with in_valid && in_ready.
- Latency:
  - Non-MUL ops: out_valid the next cycle.
  - MUL: out_valid WIDTH/MUL_BITS + 1 cycles after accept.
- While out_valid=1 and out_ready=0, result, out_* and flags hold stable.
- Flag-update timing:
  - Flags are written on the same edge the result is registered.
  - A back-to-back instruction therefore sees the flags of its predecessor.
  - cond is evaluated against the flags register at accept. The predecessor of any MUL-dependent instruction is always complete, because in_ready is low during MUL.
- Condition codes:
  - 0 EQ Z
  - 1 NE !Z
  - 2 CS C
  - 3 CC !C
  - 4 MI N
  - 5 PL !N
  - 6 VS V
  - 7 VC !V
  - 8 HI C&!Z
  - 9 LS !C|Z
  - A GE N==V
  - B LT N!=V
  - C GT !Z&(N==V)
  - D LE Z|(N!=V)
  - E and F: always
- Condition fail: out_valid after 1 cycle, out_skip=1, result=0, out_wr=0, flags unchanged, MUL not started.
- Opcodes and flag effects (flags written only when s=1, except CMP):
  - 0 ADD: A+B; C = carry out, V = signed overflow.
  - 1 SUB: A-B; C = no-borrow (A>=B unsigned), V = signed overflow.
  - 2 MUL: low WIDTH bits of A*B; N and Z updated, C and V kept.
  - 3 OR, 4 AND, 5 XOR: N and Z updated, C and V kept.
  - 6 MOVI: result = zero-extended iv.
  - 7 MOV: result = B.
  - 8 LSR, 9 LSL, A ROR:
    - Source is reg2; amount is iv[log2(WIDTH)-1:0].
    - C = last bit shifted out; for ROR, C = result MSB.
    - Amount 0: result = source, C kept.
  - B CMP: flags as SUB, always written regardless of s; out_wr=0.
  - C-F: reserved. out_illegal=1, result=0, out_wr=0, flags unchanged.
- For all flag-updating ops: N = result MSB, Z = (result==0).
- out_wr=1 for every executed op except CMP.

Optional Feature:
- Macro: ALU_CARRY_IN_EN.
- When defined:
  - Opcode C = ADC: A+B+C.
  - Opcode D = SBC: A-B-!C.
  - Flags for both as ADD/SUB.
- Opcodes E and F remain illegal.
- When undefined, opcodes C-F are all illegal.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, s=1, cond=E -> next cycle result=0x80000000, flags=4'b1001, out_wr=1.
- CMP 5,5; then ADD 1+2 with cond=0 (EQ); then ADD with cond=1 (NE):
  - CMP -> flags=4'b0110.
  - First ADD -> result=3.
  - Second ADD -> out_skip=1, result=0, flags unchanged.
- MUL 0x00010000 * 0x00010000, s=1, MUL_BITS=4 -> busy=1 and in_ready=0 for 8 cycles; out_valid on cycle 9 with result=0, flags Z=1, C and V kept.
- LSR reg2=0x80000001, iv=1, s=1 -> result=0x40000000, C=1. ROR with amount 0 -> result = reg2, C unchanged.
- out_ready held low 3 cycles after an ADD -> result, flags and out_valid stable, in_ready=0. Raise out_ready with in_valid=1 -> the next instruction is accepted in the same cycle.
- Reserved opcodes:
  - op_code=C, macro undefined -> out_illegal=1.
  - op_code=C, macro defined, C=1: 0xFFFFFFFF + 0 + 1 -> result=0, C=1, Z=1.
